// File: rtl/ber_checker_if.sv
// rtl/ber_checker_if.sv - sample/result bundle of the BER checker
// Purpose: groups the per-sample inputs and the registered results of ber_checker.
// Ports (signals):
//   in_enable     sample strobe
//   in_bit_ref    transmitted PRBS bit
//   in_bit_rx     received (sliced) bit
//   in_clear      zero the bit/error counters
//   out_lock      high while locked
//   out_delay     current alignment delay
//   out_bit_count bits compared while locked
//   out_err_count mismatches while locked
// Modports: master drives samples and reads results, slave is the checker side.
interface ber_checker_if #(
    parameter int NB_COUNT = 32,
    parameter int NB_DELAY = 9
);
    logic                in_enable;
    logic                in_bit_ref;
    logic                in_bit_rx;
    logic                in_clear;
    logic                out_lock;
    logic [NB_DELAY-1:0] out_delay;
    logic [NB_COUNT-1:0] out_bit_count;
    logic [NB_COUNT-1:0] out_err_count;

    modport master (
        output in_enable, in_bit_ref, in_bit_rx, in_clear,
        input  out_lock, out_delay, out_bit_count, out_err_count
    );

    modport slave (
        input  in_enable, in_bit_ref, in_bit_rx, in_clear,
        output out_lock, out_delay, out_bit_count, out_err_count
    );
endinterface

// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - PRBS bit-error-rate checker with automatic delay alignment
// Purpose: searches the delay between reference and received bit streams window by
// window, locks on an error-free window, then counts compared bits and mismatches.
// Ports:
//   clock     rising-edge clock
//   in_reset  synchronous active-high reset
//   bus       ber_checker_if.slave (sample inputs, registered lock/delay/counters)
module ber_checker #(
    parameter int NB_COUNT   = 32,
    parameter int NB_DELAY   = 9,
    parameter int MAX_DELAY  = 512,
    parameter int WINDOW_LEN = 1024,
    parameter int LOSS_THR   = 32
) (
    input  logic          clock,
    input  logic          in_reset,
    ber_checker_if.slave  bus
);
    localparam int NB_WIN  = $clog2(WINDOW_LEN + 1);
    localparam int NB_WERR = $clog2(WINDOW_LEN + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state, state_next;
    logic [MAX_DELAY-2:0] ref_line, ref_line_next;
    logic [MAX_DELAY-1:0] taps;
    logic [NB_WIN-1:0]    win_cnt, win_cnt_next;
    logic [NB_WERR-1:0]   win_err, win_err_next, win_err_total;
    logic [NB_DELAY-1:0]  delay, delay_next, delay_inc;
    logic [NB_COUNT-1:0]  bit_cnt, bit_cnt_next, err_cnt, err_cnt_next;
    logic                 err, win_end, saturated, too_many;

    // taps[d] is the reference d enabled samples ago; tap 0 is the live input.
    assign taps          = {ref_line, bus.in_bit_ref};
    assign err           = bus.in_bit_rx ^ taps[delay];
    assign win_err_total = win_err + NB_WERR'(err);
    assign win_end       = (win_cnt == NB_WIN'(WINDOW_LEN - 1));
    assign saturated     = &bit_cnt;
    assign too_many      = (32'(win_err_total) > 32'(LOSS_THR));
    assign delay_inc     = (delay == NB_DELAY'(MAX_DELAY - 1)) ? '0 : delay + NB_DELAY'(1);

    always_comb begin
        state_next    = state;
        delay_next    = delay;
        win_cnt_next  = win_cnt;
        win_err_next  = win_err;
        bit_cnt_next  = bit_cnt;
        err_cnt_next  = err_cnt;
        ref_line_next = ref_line;
        if (bus.in_enable) begin
            ref_line_next = taps[MAX_DELAY-2:0];
            // Counters stop once the bit count is all-ones so neither can wrap.
            if (state == LOCKED && !saturated) begin
                bit_cnt_next = bit_cnt + NB_COUNT'(1);
                err_cnt_next = err_cnt + NB_COUNT'(err);
            end
            if (win_end) begin
                win_cnt_next = '0;
                win_err_next = '0;
                case (state)
                    SEARCH: begin
                        if (win_err_total == '0) begin
                            state_next = LOCKED;
                        end else begin
                            delay_next = delay_inc;
                        end
                    end
                    LOCKED: begin
                        if (too_many) begin
                            state_next = SEARCH;
                            delay_next = delay_inc;
                        end
                    end
                    default: state_next = SEARCH;
                endcase
            end else begin
                win_cnt_next = win_cnt + NB_WIN'(1);
                win_err_next = win_err_total;
            end
        end
        // Clear wins over a simultaneous sample but leaves everything else alone.
        if (bus.in_clear) begin
            bit_cnt_next = '0;
            err_cnt_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (in_reset) begin
            state    <= SEARCH;
            delay    <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            bit_cnt  <= '0;
            err_cnt  <= '0;
            ref_line <= '0;
        end else begin
            state    <= state_next;
            delay    <= delay_next;
            win_cnt  <= win_cnt_next;
            win_err  <= win_err_next;
            bit_cnt  <= bit_cnt_next;
            err_cnt  <= err_cnt_next;
            ref_line <= ref_line_next;
        end
    end

    assign bus.out_lock      = (state == LOCKED);
    assign bus.out_delay     = delay;
    assign bus.out_bit_count = bit_cnt;
    assign bus.out_err_count = err_cnt;
endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter NB_COUNT, default 32: width of the bit and error counters.
REQ-002 Parameter NB_DELAY, default 9: width of the alignment delay index.
REQ-003 Parameter MAX_DELAY, default 512: number of candidate delays, 0..MAX_DELAY-1, with MAX_DELAY <= 2^NB_DELAY.
REQ-004 Parameter WINDOW_LEN, default 1024: number of enabled samples per alignment/monitor window.
REQ-005 Parameter LOSS_THR, default 32: window error count above which lock is dropped.
REQ-006 Port clock, input, 1: single clock; all logic is on its rising edge.
REQ-007 Port in_reset, input, 1: reset is synchronous and active-high.
REQ-008 Port in_enable, input, 1: sample strobe; all state advances only when high.
REQ-009 Port in_bit_ref, input, 1: transmitted PRBS bit (the generator output).
REQ-010 Port in_bit_rx, input, 1: received bit (the equalizer slicer decision).
REQ-011 Port in_clear, input, 1: clears the bit and error counters.
REQ-012 Port out_lock, output, 1: high while in LOCKED.
REQ-013 Port out_delay, output, NB_DELAY: current alignment delay in samples.
REQ-014 Port out_bit_count, output, NB_COUNT: number of bits compared while locked.
REQ-015 Port out_err_count, output, NB_COUNT: number of mismatches while locked.

Function
REQ-016 The block shall hold a reference delay line of MAX_DELAY-1 registers that shifts in in_bit_ref on each enabled cycle.
REQ-017 The aligned reference for delay d shall be the in_bit_ref value from d enabled samples earlier; d=0 selects the current in_bit_ref combinationally.
REQ-018 Per enabled sample, err = in_bit_rx XOR aligned reference.
REQ-019 The window counter shall count enabled samples 0..WINDOW_LEN-1, and the window error counter shall accumulate err.
REQ-020 "Window end" is the enabled sample at which the window counter equals WINDOW_LEN-1; both window counters shall clear there.
REQ-021 The state machine shall have two states, SEARCH and LOCKED.
REQ-022 SEARCH, at window end: if the window errors, including the current err, equal 0, the block shall go to LOCKED with out_delay unchanged.
REQ-023 SEARCH, at window end with nonzero errors: out_delay shall increment, wrapping from MAX_DELAY-1 to 0, and the state shall stay SEARCH.
REQ-024 In SEARCH, out_bit_count and out_err_count shall hold.
REQ-025 LOCKED, each enabled sample: out_bit_count += 1 and out_err_count += err.
REQ-026 When out_bit_count equals all-ones, both counters shall freeze (measurement complete); neither shall ever wrap.
REQ-027 LOCKED, at window end: if the window errors, including the current err, exceed LOSS_THR, the block shall go to SEARCH and increment out_delay with wrap; counters hold.
REQ-028 An error count exactly equal to LOSS_THR shall keep the block in LOCKED.
REQ-029 in_clear high shall zero out_bit_count and out_err_count on the next edge, without affecting state, out_delay, the window counters or the delay line.
REQ-030 in_clear shall take priority over a simultaneous enabled sample.
REQ-031 All outputs shall be registered, and a sample on edge n shall be visible on the outputs after edge n.
REQ-032 in_enable low shall freeze all state, except the in_clear action.

Reset
REQ-033 When in_reset is high at an edge, the block shall take state SEARCH, out_lock=0, out_delay=0, both counters=0, window counters=0 and delay line all zeros, overriding in_enable and in_clear.
REQ-034 Reset mid-window or while LOCKED shall discard all progress, and the search shall restart at delay 0 on the first enabled sample after release.

Verification
REQ-035 PRBS ref with rx = ref delayed 5 samples, in_enable always high -> out_delay steps 0..5 at window ends; out_lock rises after 6*1024 samples; out_delay=5; out_err_count=0.
REQ-036 Locked, with one flipped rx bit every 100 samples -> out_err_count increments by 1 each time, out_lock stays 1 (about 10 errors per window <= 32), out_bit_count equals the samples since lock.
REQ-037 Locked, then rx inverted -> at the next window end out_lock=0, out_delay=6, and counters hold their pre-loss values.
REQ-038 Locked, in_clear and in_enable high together with err=1 -> both counters 0 on the next cycle; out_lock unchanged.
REQ-039 NB_COUNT=8, locked, rx flipped every other sample with LOSS_THR=1023 -> out_bit_count freezes at 255, and out_err_count freezes at 128 (or the exact count at that point) and holds.
REQ-040 in_reset pulsed while locked at out_delay=5 -> next cycle out_lock=0, out_delay=0, counters 0; re-lock occurs after 6 further windows.
